// File: rtl/terminal_rx.sv
// Memory-mapped terminal input port: bytes strobed in by an external source are
// buffered in a FIFO and popped by CPU loads of DATA. Optional irq: TERMINAL_RX_IRQ_EN.
module terminal_rx #(
   parameter int          DEPTH     = 16,
   parameter logic [31:0] ADDR_BASE = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        re,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] data_write,
   output logic [31:0] data_read,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        irq
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      OFF_DATA   = 2'd0,
      OFF_STATUS = 2'd1,
      OFF_CTRL   = 2'd2,
      OFF_RSVD   = 2'd3
   } offset_t;

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [AW:0]   count_r;
   logic          overflow_r;
   logic          ctrl_ie_r;

   logic          hit_s;
   offset_t       offset_s;
   logic          empty_s;
   logic          full_s;
   logic          pop_s;
   logic          push_s;
   logic          ctrl_wr_s;
   logic          flush_s;
   logic          clr_ovf_s;
   logic          ovf_event_s;
   logic          mem_we_s;
   logic [7:0]    head_s;
   logic [AW-1:0] rd_ptr_next_s;
   logic [AW-1:0] wr_ptr_next_s;
   logic [AW:0]   count_next_s;
   logic          overflow_next_s;
   logic          ctrl_ie_next_s;
   logic          unused_s;

   assign unused_s = ^{data_write[31:3], addr[1:0]};

   // Address decode, FIFO status and event qualification
   always_comb begin
      hit_s       = (addr[31:4] == ADDR_BASE[31:4]);
      offset_s    = offset_t'(addr[3:2]);
      empty_s     = (count_r == {(AW+1){1'b0}});
      full_s      = (count_r == FULL_CNT);
      pop_s       = re && hit_s && (offset_s == OFF_DATA) && !empty_s;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
      push_s      = in_valid && (!full_s || pop_s);
      ctrl_wr_s   = we && hit_s && (offset_s == OFF_CTRL);
      flush_s     = ctrl_wr_s && data_write[0];
      clr_ovf_s   = ctrl_wr_s && data_write[1];
      ovf_event_s = in_valid && full_s && !pop_s && !flush_s;
      mem_we_s    = push_s && !flush_s && reset_n;
      head_s      = empty_s ? 8'h00 : mem_r[rd_ptr_r];
   end

   // Next-state computation for pointers, count and flags
   always_comb begin
      rd_ptr_next_s   = rd_ptr_r;
      wr_ptr_next_s   = wr_ptr_r;
      count_next_s    = count_r;
      overflow_next_s = overflow_r;
      ctrl_ie_next_s  = ctrl_ie_r;
      if (flush_s) begin
         rd_ptr_next_s = {AW{1'b0}};
         wr_ptr_next_s = {AW{1'b0}};
         count_next_s  = {(AW+1){1'b0}};
      end else begin
         if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + AW'(1);
         end else begin
            rd_ptr_next_s = rd_ptr_r;
         end
         if (push_s) begin
            wr_ptr_next_s = wr_ptr_r + AW'(1);
         end else begin
            wr_ptr_next_s = wr_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + (AW+1)'(1);
            2'b01:   count_next_s = count_r - (AW+1)'(1);
            default: count_next_s = count_r;
         endcase
      end
      // Set wins over a same-cycle clear.
      if (ovf_event_s) begin
         overflow_next_s = 1'b1;
      end else if (clr_ovf_s) begin
         overflow_next_s = 1'b0;
      end else begin
         overflow_next_s = overflow_r;
      end
      if (ctrl_wr_s) begin
         ctrl_ie_next_s = data_write[2];
      end else begin
         ctrl_ie_next_s = ctrl_ie_r;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_ptr_r   <= {AW{1'b0}};
         wr_ptr_r   <= {AW{1'b0}};
         count_r    <= {(AW+1){1'b0}};
         overflow_r <= 1'b0;
         ctrl_ie_r  <= 1'b0;
      end else begin
         rd_ptr_r   <= rd_ptr_next_s;
         wr_ptr_r   <= wr_ptr_next_s;
         count_r    <= count_next_s;
         overflow_r <= overflow_next_s;
         ctrl_ie_r  <= ctrl_ie_next_s;
      end
   end

   // FIFO storage; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[wr_ptr_r] <= in_data;
      end
   end

   // Combinational register read mux
   always_comb begin
      data_read = 32'h0000_0000;
      if (re && hit_s) begin
         case (offset_s)
            OFF_DATA:   data_read = {23'h0, !empty_s, head_s};
            OFF_STATUS: data_read = {16'h0, 8'(count_r), 5'h0, overflow_r, full_s, empty_s};
            OFF_CTRL:   data_read = {29'h0, ctrl_ie_r, 2'b00};
            OFF_RSVD:   data_read = 32'h0000_0000;
            default:    data_read = 32'h0000_0000;
         endcase
      end else begin
         data_read = 32'h0000_0000;
      end
   end

`ifdef TERMINAL_RX_IRQ_EN
   logic irq_r;

   // Registered interrupt: pending data or overflow while enabled
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= ctrl_ie_next_s && ((count_next_s != {(AW+1){1'b0}}) || overflow_next_s);
      end
   end

   assign irq = irq_r;
`else
   assign irq = 1'b0;
`endif

endmodule
